echo_decimator: RTL and testbench

Boxcar decimator sitting between the ADC capture register and the A-scan sample memory. It sums each group of 2^LOG2_N consecutive valid 8-bit echo samples in a 16-bit accumulator and emits one averaged 8-bit sample per group. Each scan produces exactly `len` output points and is bracketed by `start` and a `done` pulse. Accumulation and counting are built on the codebase's ripple `add16` and `inc16` arithmetic blocks.

---
 rtl/echo_pkg.sv | 32 +++
 rtl/echo_decimator_if.sv | 26 ++
 rtl/add16.sv | 18 +
 rtl/echo_decim_acc.sv | 45 ++++
 rtl/inc16.sv | 17 +
 rtl/echo_decimator.sv | 97 +++++++++
 tb/tb_echo_decimator.sv | 237 +++++++++++++++++++++++
 7 files changed

// File: rtl/echo_pkg.sv
// Shared types, widths and the averaging helper for the echo decimator.
// Rounding of the averaged sample is selected by ECHO_DECIM_ROUND_EN (default: truncate).
package echo_pkg;

  localparam int ECHO_SAMPLE_W    = 8;
  localparam int ECHO_ACC_W       = 16;
  localparam int ECHO_LOG2_N_MAX  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } echo_state_t;

  // Scale a group sum back to sample range; the sum of 2^log2_n samples
  // shifted by log2_n can never exceed 255, saturation only guards rounding.
  function automatic logic [ECHO_SAMPLE_W-1:0] echo_avg(
    input logic [ECHO_ACC_W-1:0] sum,
    input int                    log2_n
  );
`ifdef ECHO_DECIM_ROUND_EN
    logic [ECHO_ACC_W:0] t;
    t = {1'b0, sum};
    if (log2_n > 0) t = t + (17'd1 << (log2_n - 1));
    t = t >> log2_n;
    return (t > 17'd255) ? 8'hFF : t[7:0];
`else
    return 8'(sum >> log2_n);
`endif
  endfunction

endpackage

// File: rtl/echo_decimator_if.sv
// Scan control, sample input and averaged-sample output bundle of the echo decimator.
// master drives start/len/samples, slave is the decimator.
interface echo_decimator_if;
  import echo_pkg::*;

  logic                     start;
  logic [ECHO_ACC_W-1:0]    len;
  logic [ECHO_SAMPLE_W-1:0] din;
  logic                     din_valid;
  logic [ECHO_SAMPLE_W-1:0] dout;
  logic                     dout_valid;
  logic [ECHO_ACC_W-1:0]    sum_out;
  logic                     busy;
  logic                     done;

  modport master (
    output start, len, din, din_valid,
    input  dout, dout_valid, sum_out, busy, done
  );

  modport slave (
    input  start, len, din, din_valid,
    output dout, dout_valid, sum_out, busy, done
  );

endinterface

// File: rtl/add16.sv
// 16-bit ripple-carry adder, purely combinational.
// No carry in/out: callers guarantee the sum fits.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s
);

  logic [16:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

endmodule

// File: rtl/echo_decim_acc.sv
// Group accumulator: running sum plus sample-in-group counter, cleared per group.
// acc_next/grp_last are combinational for the current sample; stalls when en is low.
module echo_decim_acc
  import echo_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [ECHO_SAMPLE_W-1:0] din,
  output logic [ECHO_ACC_W-1:0]    acc_next,
  output logic                     grp_last
);

  localparam logic [7:0] GRP_LAST = 8'((1 << LOG2_N) - 1);

  logic [ECHO_ACC_W-1:0] acc;
  logic [7:0]            grp_cnt;

  add16 u_add (
    .a (acc),
    .b ({8'd0, din}),
    .s (acc_next)
  );

  assign grp_last = (grp_cnt == GRP_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc     <= '0;
      grp_cnt <= '0;
    end else if (en) begin
      if (grp_last) begin
        acc     <= '0;
        grp_cnt <= '0;
      end else begin
        acc     <= acc_next;
        grp_cnt <= grp_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/inc16.sv
// 16-bit ripple incrementer, purely combinational.
// Wraps silently at 16'hFFFF.
module inc16 (
  input  logic [15:0] a,
  output logic [15:0] y
);

  logic [16:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign y[i]   = a[i] ^ c[i];
    assign c[i+1] = a[i] & c[i];
  end

endmodule

// File: rtl/echo_decimator.sv
// Boxcar decimator: one averaged sample per 2^LOG2_N valid inputs, len points per scan, 1-cycle latency.
// No backpressure, one sample per cycle; rounding via ECHO_DECIM_ROUND_EN (default truncate).
module echo_decimator #(
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  echo_decimator_if.slave   bus
);
  import echo_pkg::*;

  echo_state_t           state, state_next;
  logic [ECHO_ACC_W-1:0] len_r;
  logic [ECHO_ACC_W-1:0] pt_cnt;
  logic [ECHO_ACC_W-1:0] pt_next;
  logic [ECHO_ACC_W-1:0] acc_next;
  logic                  grp_last;
  logic                  acc_clr;
  logic                  acc_en;
  logic                  emit;
  logic                  done_next;

  echo_decim_acc #(
    .LOG2_N (LOG2_N)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .en       (acc_en),
    .din      (bus.din),
    .acc_next (acc_next),
    .grp_last (grp_last)
  );

  inc16 u_pt_inc (
    .a (pt_cnt),
    .y (pt_next)
  );

  // busy stays high through the done cycle, so a start there is still ignored
  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    emit       = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.busy) begin
          acc_clr    = 1'b1;
          state_next = (bus.len == '0) ? FIN : ACC;
        end
      end
      ACC: begin
        acc_en = bus.din_valid;
        if (bus.din_valid && grp_last) begin
          emit = 1'b1;
          if (pt_next == len_r) state_next = FIN;
        end
      end
      FIN: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      len_r          <= '0;
      pt_cnt         <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.sum_out    <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state <= state_next;
      if (acc_clr) begin
        len_r  <= bus.len;
        pt_cnt <= '0;
      end else if (emit) begin
        pt_cnt <= pt_next;
      end
      bus.dout_valid <= emit;
      if (emit) begin
        bus.sum_out <= acc_next;
        bus.dout    <= echo_avg(acc_next, LOG2_N);
      end
      bus.done <= done_next;
      bus.busy <= (state_next != IDLE) || (state == FIN);
    end
  end

endmodule

// File: tb/tb_echo_decimator.sv
// Drives three decimators (LOG2_N = 3, 8, 0) with shared stimulus and compares every
// cycle against a group-sum reference model; honours ECHO_DECIM_ROUND_EN.
module tb_echo_decimator;

  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_FIN  = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic [7:0]  din;
  logic        din_valid;

  int n_chk  = 0;
  int n_pass = 0;
  int dv3_cnt = 0;

  echo_decimator_if bus3 ();
  echo_decimator_if bus8 ();
  echo_decimator_if bus0 ();

  assign bus3.start = start;  assign bus3.len = len;  assign bus3.din = din;  assign bus3.din_valid = din_valid;
  assign bus8.start = start;  assign bus8.len = len;  assign bus8.din = din;  assign bus8.din_valid = din_valid;
  assign bus0.start = start;  assign bus0.len = len;  assign bus0.din = din;  assign bus0.din_valid = din_valid;

  echo_decimator #(.LOG2_N(3)) u3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  echo_decimator #(.LOG2_N(8)) u8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  echo_decimator #(.LOG2_N(0)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state, index 0/1/2 -> LOG2_N 3/8/0
  int lg [3] = '{3, 8, 0};
  int ph [3];
  int lenr [3];
  int pts [3];
  int gsum [3];
  int gcnt [3];
  int e_dout [3];
  int e_sum [3];
  bit e_dv [3];
  bit e_done [3];
  bit e_busy [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int ref_avg(input int s, input int l);
    int d;
    int r;
    d = 1 << l;
`ifdef ECHO_DECIM_ROUND_EN
    r = (l == 0) ? s : (s + d / 2) / d;
`else
    r = s / d;
`endif
    return (r > 255) ? 255 : r;
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_step();
    int old;
    for (int k = 0; k < 3; k++) begin
      e_dv[k]   = 1'b0;
      e_done[k] = 1'b0;
      if (rst) begin
        ph[k] = P_IDLE; e_dout[k] = 0; e_sum[k] = 0; e_busy[k] = 1'b0;
        gsum[k] = 0; gcnt[k] = 0; pts[k] = 0;
      end else begin
        old = ph[k];
        if (old == P_IDLE) begin
          if (start && !e_busy[k]) begin
            lenr[k] = int'(len); pts[k] = 0; gsum[k] = 0; gcnt[k] = 0;
            ph[k] = (len == 16'd0) ? P_FIN : P_ACC;
          end
        end else if (old == P_ACC) begin
          if (din_valid) begin
            gsum[k] += int'(din);
            gcnt[k]++;
            if (gcnt[k] == (1 << lg[k])) begin
              e_sum[k]  = gsum[k];
              e_dout[k] = ref_avg(gsum[k], lg[k]);
              e_dv[k]   = 1'b1;
              gsum[k] = 0; gcnt[k] = 0;
              pts[k]++;
              if (pts[k] == lenr[k]) ph[k] = P_FIN;
            end
          end
        end else begin
          e_done[k] = 1'b1;
          ph[k] = P_IDLE;
        end
        e_busy[k] = (ph[k] != P_IDLE) || (old == P_FIN);
      end
    end
  endtask

  task automatic check_inst(input int k, input logic [7:0] d, input logic dv,
                            input logic [15:0] s, input logic b, input logic dn);
    string p;
    p = $sformatf("L%0d", lg[k]);
    check({p, ".dout_valid"}, 32'(dv), 32'(e_dv[k]));
    check({p, ".dout"},       32'(d),  32'(e_dout[k]));
    check({p, ".sum_out"},    32'(s),  32'(e_sum[k]));
    check({p, ".busy"},       32'(b),  32'(e_busy[k]));
    check({p, ".done"},       32'(dn), 32'(e_done[k]));
  endtask

  // One clock: check outputs of the last edge, then predict the next edge.
  task automatic cycle();
    @(negedge clk);
    if (bus3.dout_valid === 1'b1) dv3_cnt++;
    check_inst(0, bus3.dout, bus3.dout_valid, bus3.sum_out, bus3.busy, bus3.done);
    check_inst(1, bus8.dout, bus8.dout_valid, bus8.sum_out, bus8.busy, bus8.done);
    check_inst(2, bus0.dout, bus0.dout_valid, bus0.sum_out, bus0.busy, bus0.done);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0; din_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; din_valid = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    dv3_cnt = 0;
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1; len = 16'(l); din_valid = 1'b0;
    cycle();
    start = 1'b0;
  endtask

  task automatic feed(input int v, input bit vld);
    din = 8'(v); din_valid = vld;
    cycle();
    din_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ph[k] = P_IDLE; lenr[k] = 0; pts[k] = 0; gsum[k] = 0; gcnt[k] = 0;
      e_dout[k] = 0; e_sum[k] = 0; e_dv[k] = 0; e_done[k] = 0; e_busy[k] = 0;
    end
    rst = 1'b1; start = 1'b0; len = '0; din = '0; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("reset.busy", 32'(bus3.busy), 0);
    check("reset.sum_out", 32'(bus8.sum_out), 0);

    // ramp 1..8, single point
    pulse_start(1);
    for (int i = 1; i <= 8; i++) feed(i, 1'b1);
    idle(3);
    check("ramp.sum_out", 32'(bus3.sum_out), 36);
`ifdef ECHO_DECIM_ROUND_EN
    check("ramp.dout", 32'(bus3.dout), 5);
`else
    check("ramp.dout", 32'(bus3.dout), 4);
`endif

    // full-scale samples with valid gaps, two points
    do_reset();
    pulse_start(2);
    for (int i = 0; i < 32; i++) feed(255, (i % 2) == 0);
    idle(3);
    check("gap.pts", 32'(dv3_cnt), 2);
    check("gap.sum_out", 32'(bus3.sum_out), 2040);
    check("gap.dout", 32'(bus3.dout), 255);

    // largest group
    do_reset();
    pulse_start(1);
    repeat (256) feed(255, 1'b1);
    idle(3);
    check("max.sum_out", 32'(bus8.sum_out), 65280);
    check("max.dout", 32'(bus8.dout), 255);

    // empty scan
    do_reset();
    pulse_start(0);
    idle(4);
    check("empty.pts", 32'(dv3_cnt), 0);

    // abort after 5 samples, reset coinciding with start, then a clean scan
    do_reset();
    pulse_start(1);
    repeat (5) feed(7, 1'b1);
    rst = 1'b1; start = 1'b1; len = 16'd1;
    cycle();
    rst = 1'b0; start = 1'b0;
    idle(2);
    pulse_start(1);
    repeat (8) feed(10, 1'b1);
    idle(3);
    check("abort.sum_out", 32'(bus3.sum_out), 80);
    check("abort.dout", 32'(bus3.dout), 10);

    // start while busy must not relatch len
    do_reset();
    pulse_start(3);
    repeat (10) feed(3, 1'b1);
    pulse_start(7);
    repeat (40) feed(3, 1'b1);
    idle(3);
    check("restart.pts", 32'(dv3_cnt), 3);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      start     = ($urandom_range(0, 19) == 0);
      len       = 16'($urandom_range(0, 4));
      din       = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
